// File: rtl/i2s_sample_rx.sv
// I2S single-channel receiver: synchronises bclk/lrclk/sdata into clk, deserialises
// one channel MSB-first into WIDTH-bit words and flags frames that end early.
module i2s_sample_rx #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int CHANNEL     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             i2s_bclk,
   input  logic             i2s_lrclk,
   input  logic             i2s_sdata,
   output logic [WIDTH-1:0] SampleIn,
   output logic             ready,
   output logic             FrameErr,
   output logic [4:0]       BitCount
);

   // Handshake: ready is a one-clk strobe meaning SampleIn changed this cycle;
   // there is no backpressure, so the sink must take SampleIn while ready=1.

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DELAY = 3'd1,
      SHIFT = 3'd2,
      DONE  = 3'd3,
      HOLD  = 3'd4
   } stateT;

   localparam logic       chanLvl = (CHANNEL != 0);
   localparam logic [4:0] lastBit = 5'(WIDTH - 1);
   localparam logic [4:0] fullCnt = 5'(WIDTH);

   logic [SYNC_STAGES-1:0] bclkSync;
   logic [SYNC_STAGES-1:0] lrSync;
   logic [SYNC_STAGES-1:0] dataSync;
   logic                   bclkPrev;
   logic                   tick;
   logic                   lrTick;
   logic                   dataTick;
   logic                   lrPrev;
   logic [WIDTH-1:0]       shiftReg;
   stateT                  state;

   // tick, lrTick and dataTick are registered together so lr and sdata are
   // always the values seen at the same bclk rise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bclkSync <= '0;
         lrSync   <= '0;
         dataSync <= '0;
         bclkPrev <= 1'b0;
         tick     <= 1'b0;
         lrTick   <= 1'b0;
         dataTick <= 1'b0;
      end else begin
         bclkSync <= {bclkSync[SYNC_STAGES-2:0], i2s_bclk};
         lrSync   <= {lrSync[SYNC_STAGES-2:0], i2s_lrclk};
         dataSync <= {dataSync[SYNC_STAGES-2:0], i2s_sdata};
         bclkPrev <= bclkSync[SYNC_STAGES-1];
         tick     <= ~bclkPrev & bclkSync[SYNC_STAGES-1];
         lrTick   <= lrSync[SYNC_STAGES-1];
         dataTick <= dataSync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         shiftReg <= '0;
         SampleIn <= '0;
         ready    <= 1'b0;
         FrameErr <= 1'b0;
         BitCount <= '0;
         lrPrev   <= 1'b0;
      end else begin
         ready    <= 1'b0;
         FrameErr <= 1'b0;
         if (tick) lrPrev <= lrTick;
         if (!enable) begin
            state    <= IDLE;
            BitCount <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (tick && (lrTick != lrPrev) && (lrTick == chanLvl))
                     state <= DELAY;
               end
               DELAY: begin
                  if (tick) begin
                     shiftReg <= {shiftReg[WIDTH-2:0], dataTick};
                     BitCount <= 5'd1;
                     state    <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (tick) begin
                     // The LSB slot may already sit after the lrclk edge, so the
                     // final bit is taken regardless of lr.
                     if (BitCount == lastBit) begin
                        shiftReg <= {shiftReg[WIDTH-2:0], dataTick};
                        BitCount <= fullCnt;
                        state    <= DONE;
                     end else if (lrTick != chanLvl) begin
                        FrameErr <= 1'b1;
                        BitCount <= '0;
                        state    <= IDLE;
                     end else begin
                        shiftReg <= {shiftReg[WIDTH-2:0], dataTick};
                        BitCount <= BitCount + 5'd1;
                     end
                  end
               end
               DONE: begin
                  SampleIn <= shiftReg;
                  ready    <= 1'b1;
                  state    <= HOLD;
               end
               HOLD: begin
                  if (tick && (lrTick != chanLvl)) begin
                     BitCount <= '0;
                     state    <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Directed bench for i2s_sample_rx: drives I2S slots at bclk = clk/8 and checks
// ready/FrameErr/SampleIn every cycle against a slot-level frame model.
module tb_i2s_sample_rx;

   localparam int  LAT_RDY = 5;   // SYNC_STAGES + 3 clk from bclk rise to ready
   localparam int  LAT_ERR = 4;   // FrameErr is registered one clk before a ready would be
   localparam logic CH     = 1'b0;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;
   logic [15:0] SampleIn;
   logic        ready;
   logic        FrameErr;
   logic [4:0]  BitCount;

   i2s_sample_rx #(.WIDTH(16), .SYNC_STAGES(2), .CHANNEL(0)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .i2s_bclk (i2s_bclk),
      .i2s_lrclk(i2s_lrclk),
      .i2s_sdata(i2s_sdata),
      .SampleIn (SampleIn),
      .ready    (ready),
      .FrameErr (FrameErr),
      .BitCount (BitCount)
   );

   // clock / cycle counter
   int cyc = 0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int readyCount = 0;
   int errCount = 0;

   // scoreboard
   logic [15:0] exp_q[$];
   int          rdyCyc_q[$];
   int          errCyc_q[$];
   logic [15:0] modelSample = 16'h0;

   // frame model state: slots seen since the lrclk edge into the channel (-1 = none)
   int          mPos = -1;
   logic [15:0] mWord = 16'h0;
   logic        mLrPrev = 1'b0;
   logic        carry = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic slotBit(input logic [15:0] w, input int k);
      if (k >= 1 && k <= 16) return w[16-k];
      return 1'b0;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      rdyCyc_q.delete();
      errCyc_q.delete();
      modelSample = 16'h0;
      mPos = -1;
      mLrPrev = 1'b0;
   endtask

   // Bits 1..16 after the lrclk edge form the word; leaving the channel before
   // bit 16 is an error (bit 1 rides on the delay slot and is never checked).
   task automatic model_rise(input logic lr, input logic d);
      if (!enable) mPos = -1;
      else if (mPos < 0) begin
         if (lr != mLrPrev && lr == CH) mPos = 0;
      end else if (mPos >= 16) begin
         if (lr != CH) mPos = -1;
      end else begin
         mPos++;
         if (mPos >= 2 && mPos <= 15 && lr != CH) begin
            errCyc_q.push_back(cyc + LAT_ERR);
            mPos = -1;
         end else begin
            mWord = {mWord[14:0], d};
            if (mPos == 16) begin
               exp_q.push_back(mWord);
               rdyCyc_q.push_back(cyc + LAT_RDY);
            end
         end
      end
      mLrPrev = lr;
   endtask

   // one bclk period: 4 clk low, rise, 4 clk high; starts on a clk negedge
   task automatic slot(input logic lr, input logic d, input logic rstHere, input logic dropEn);
      i2s_bclk  = 1'b0;
      i2s_lrclk = lr;
      i2s_sdata = d;
      if (dropEn) enable = 1'b0;
      @(negedge clk);
      if (rstHere) begin
         #2 reset = 1'b0;
         #1;
         check("rst_async_SampleIn", 32'(SampleIn), 32'h0);
         check("rst_async_ready", 32'(ready), 32'h0);
         check("rst_async_FrameErr", 32'(FrameErr), 32'h0);
         check("rst_async_BitCount", 32'(BitCount), 32'h0);
         model_reset();
         @(negedge clk);
         reset = 1'b1;
         repeat (2) @(negedge clk);
      end else begin
         repeat (3) @(negedge clk);
      end
      i2s_bclk = 1'b1;
      model_rise(lr, d);
      repeat (4) @(negedge clk);
   endtask

   task automatic half(input logic lr, input logic [15:0] word, input int nslots,
                       input int rstSlot, input int dropSlot);
      logic d;
      for (int k = 0; k < nslots; k++) begin
         d = (k == 0) ? carry : slotBit(word, k);
         if (k == rstSlot) check("bitcount_before_reset", 32'(BitCount), 32'(k - 1));
         slot(lr, d, k == rstSlot, k == dropSlot);
      end
      carry = slotBit(word, nslots);
   endtask

   task automatic frame(input logic [15:0] left, input logic [15:0] right);
      half(1'b0, left, 16, -1, -1);
      half(1'b1, right, 16, -1, -1);
   endtask

   // per-cycle compare
   always @(negedge clk) begin
      logic expR;
      logic expE;
      if (reset) begin
         expR = (rdyCyc_q.size() > 0 && rdyCyc_q[0] == cyc);
         expE = (errCyc_q.size() > 0 && errCyc_q[0] == cyc);
         if (expR) begin
            modelSample = exp_q.pop_front();
            void'(rdyCyc_q.pop_front());
         end
         if (expE) void'(errCyc_q.pop_front());
         check("ready", 32'(ready), 32'(expR));
         check("FrameErr", 32'(FrameErr), 32'(expE));
         check("SampleIn", 32'(SampleIn), 32'(modelSample));
         if (ready) readyCount++;
         if (FrameErr) errCount++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   initial begin
      int rc;
      int ec;
      logic [15:0] rw;
      reset     = 1'b0;
      enable    = 1'b1;
      i2s_bclk  = 1'b0;
      i2s_lrclk = 1'b1;
      i2s_sdata = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_SampleIn", 32'(SampleIn), 32'h0);
      check("reset_ready", 32'(ready), 32'h0);
      check("reset_FrameErr", 32'(FrameErr), 32'h0);
      check("reset_BitCount", 32'(BitCount), 32'h0);
      reset = 1'b1;
      @(negedge clk);

      half(1'b1, 16'h0000, 16, -1, -1);

      // left 0xA5C3 captured, right 0x1234 ignored
      rc = readyCount; ec = errCount;
      frame(16'hA5C3, 16'h1234);
      check("t1_ready_count", 32'(readyCount - rc), 32'd1);
      check("t1_SampleIn", 32'(SampleIn), 32'hA5C3);
      check("t2_no_err", 32'(errCount - ec), 32'd0);

      // left cut short after 9 bits
      rc = readyCount; ec = errCount;
      rw = 16'($urandom_range(0, 65535));
      half(1'b0, 16'hDEAD, 10, -1, -1);
      half(1'b1, rw, 16, -1, -1);
      check("t3_err_count", 32'(errCount - ec), 32'd1);
      check("t3_no_ready", 32'(readyCount - rc), 32'd0);
      check("t3_SampleIn_held", 32'(SampleIn), 32'hA5C3);
      rw = 16'($urandom_range(0, 65535));
      frame(16'h7FFF, rw);
      check("t3_SampleIn", 32'(SampleIn), 32'h7FFF);

      // back-to-back frames
      rc = readyCount;
      frame(16'h8000, 16'($urandom_range(0, 65535)));
      check("t4_first", 32'(SampleIn), 32'h8000);
      frame(16'hFFFF, 16'($urandom_range(0, 65535)));
      frame(16'h0001, 16'($urandom_range(0, 65535)));
      check("t4_ready_count", 32'(readyCount - rc), 32'd3);
      check("t4_SampleIn", 32'(SampleIn), 32'h0001);

      // enable dropped after 5 bits
      rc = readyCount; ec = errCount;
      half(1'b0, 16'h3333, 16, -1, 6);
      check("t5_SampleIn_kept", 32'(SampleIn), 32'h0001);
      enable = 1'b1;
      half(1'b1, 16'($urandom_range(0, 65535)), 16, -1, -1);
      frame(16'h0F0F, 16'($urandom_range(0, 65535)));
      check("t5_no_err", 32'(errCount - ec), 32'd0);
      check("t5_ready_count", 32'(readyCount - rc), 32'd1);
      check("t5_SampleIn", 32'(SampleIn), 32'h0F0F);

      // 20-slot left half: extra bits dropped
      ec = errCount;
      half(1'b0, 16'h9ABC, 20, -1, -1);
      half(1'b1, 16'($urandom_range(0, 65535)), 16, -1, -1);
      check("trunc_SampleIn", 32'(SampleIn), 32'h9ABC);
      check("trunc_no_err", 32'(errCount - ec), 32'd0);

      // reset in the middle of a word
      half(1'b0, 16'hBEEF, 16, 8, -1);
      half(1'b1, 16'($urandom_range(0, 65535)), 16, -1, -1);
      check("t6_SampleIn_after_reset", 32'(SampleIn), 32'h0);
      frame(16'hC3A5, 16'($urandom_range(0, 65535)));
      check("t6_SampleIn", 32'(SampleIn), 32'hC3A5);

      repeat (20) @(negedge clk);
      check("pending_events", 32'(rdyCyc_q.size() + errCyc_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
